param_register_file: RTL and testbench

Parametrised integer register file for the single-cycle processor, replacing the fixed 32x64, two-read-port file. It has a configurable word width, register count and read-port count. Register x0 is hardwired to zero. A hardware clear sequencer zeroes every register after reset or on request and raises `ready` when done. An optional write-to-read bypass is available. It sits between the decode stage (addresses), the writeback mux (`write_data`) and the ALU operand inputs.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_seq.sv | 70 +++++++
 rtl/param_register_file.sv | 75 +++++++
 tb/tb_param_register_file.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parametrised integer register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } regfile_state_t;

    localparam int XLEN_DEFAULT     = 64;
    localparam int NREGS_DEFAULT    = 32;
    localparam int NUM_READ_DEFAULT = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps registers 1..NREGS-1 to zero after reset or on request,
// then reports the file as ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int  NREGS = NREGS_DEFAULT,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_request,
    output logic          clear_active,
    output logic [AW-1:0] clear_index,
    output logic          ready
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    regfile_state_t state_q, state_d;
    logic [AW-1:0]  count_q, count_d;
    logic           ready_q;

    // Next-state logic: a request in either state restarts the sweep at x1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            CLEAR: begin
                if (clear_request) begin
                    count_d = FIRST_IDX;
                end else if (count_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    count_d = count_q + AW'(1);
                end
            end
            READY: begin
                if (clear_request) begin
                    state_d = CLEAR;
                    count_d = FIRST_IDX;
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = CLEAR;
                count_d = FIRST_IDX;
            end
        endcase
    end

    // State, counter and registered ready flag; reset outranks any request.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            count_q <= FIRST_IDX;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (state_d == READY);
        end
    end

    assign clear_active = (state_q == CLEAR);
    assign clear_index  = count_q;
    assign ready        = ready_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file with hardwired x0, hardware clear sweep and
// NUM_READ combinational read ports. Optional same-cycle write bypass: PARAM_REGFILE_BYPASS_EN.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  NREGS    = NREGS_DEFAULT,
    parameter int  NUM_READ = NUM_READ_DEFAULT,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_request,
    input  logic                     reg_write,
    input  logic [AW-1:0]            rd_address,
    input  logic [XLEN-1:0]          write_data,
    input  logic [NUM_READ*AW-1:0]   rs_address,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    output logic                     ready
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            clear_active_s;
    logic [AW-1:0]   clear_index_s;
    logic            wr_en_s;

    regfile_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear_request (clear_request),
        .clear_active  (clear_active_s),
        .clear_index   (clear_index_s),
        .ready         (ready)
    );

    assign wr_en_s = reg_write && (rd_address != {AW{1'b0}}) &&
                     !clear_active_s && !clear_request;

    // Storage has no reset so it stays RAM-inferable; the sweep does the zeroing.
    always_ff @(posedge clock) begin
        if (reset_n && clear_active_s) begin
            regs_q[clear_index_s] <= {XLEN{1'b0}};
        end else if (wr_en_s) begin
            regs_q[rd_address] <= write_data;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] val_s;

        assign addr_s = rs_address[p*AW +: AW];

        // Read mux: x0 and the clearing window always read as zero.
        always_comb begin
            val_s = {XLEN{1'b0}};
            if (addr_s == {AW{1'b0}}) begin
                val_s = {XLEN{1'b0}};
            end else if (clear_active_s) begin
                val_s = {XLEN{1'b0}};
`ifdef PARAM_REGFILE_BYPASS_EN
            end else if (wr_en_s && (rd_address == addr_s)) begin
                val_s = write_data;
`endif
            end else begin
                val_s = regs_q[addr_s];
            end
        end

        assign rs_data[p*XLEN +: XLEN] = val_s;
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file at default sizing.
module tb_param_register_file;
    import regfile_pkg::*;

    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int NR = 2;
    localparam int AW = 5;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            clear_request;
    logic            reg_write;
    logic [AW-1:0]   rd_address;
    logic [XLEN-1:0] write_data;
    logic [NR*AW-1:0]   rs_address;
    logic [NR*XLEN-1:0] rs_data;
    logic            ready;

    int checks = 0;
    int errors = 0;
    int n;

    param_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NUM_READ(NR)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear_request (clear_request),
        .reg_write     (reg_write),
        .rd_address    (rd_address),
        .write_data    (write_data),
        .rs_address    (rs_address),
        .rs_data       (rs_data),
        .ready         (ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rs(input int a0, input int a1);
        rs_address = {AW'(a1), AW'(a0)};
        #1;
    endtask

    function automatic logic [XLEN-1:0] port(input int p);
        return rs_data[p*XLEN +: XLEN];
    endfunction

    // Counts edges until ready is seen; every CLEAR cycle must read zero on both ports.
    task automatic wait_ready(output int cnt);
        bit zero_ok;
        zero_ok = 1'b1;
        cnt = 0;
        while (!ready && cnt < 200) begin
            tick();
            #1;
            cnt++;
            if (!ready && (rs_data !== '0)) zero_ok = 1'b0;
        end
        check("ports_zero_during_clear", {63'd0, zero_ok}, 64'd1);
    endtask

    task automatic write_reg(input int a, input logic [XLEN-1:0] d);
        reg_write = 1'b1;
        rd_address = AW'(a);
        write_data = d;
        tick();
        reg_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_request = 1'b0;
        reg_write = 1'b0;
        rd_address = '0;
        write_data = '0;
        rs_address = {5'd31, 5'd5};
        @(negedge clock);
        tick();
        #1;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_rs_data0", port(0), 64'd0);
        check("reset_rs_data1", port(1), 64'd0);

        // Initial sweep
        reset_n = 1'b1;
        wait_ready(n);
        check("init_sweep_edges", 64'(n), 64'd31);
        for (int r = 0; r < NREGS; r++) begin
            set_rs(r, NREGS - 1 - r);
            check($sformatf("init_zero_x%0d", r), port(0), 64'd0);
        end

        // Normal writes and x0
        write_reg(5, 64'h1111);
        write_reg(0, 64'hDEADBEEF);
        set_rs(5, 0);
        check("x5_write", port(0), 64'h1111);
        check("x0_hardwired", port(1), 64'd0);

        // Writes during CLEAR are dropped
        clear_request = 1'b1;
        tick();
        clear_request = 1'b0;
        #1;
        check("clear_ready_low", {63'd0, ready}, 64'd0);
        repeat (15) tick();
        reg_write = 1'b1;
        rd_address = 5'd10;
        write_data = 64'hAAAA;
        repeat (5) tick();
        reg_write = 1'b0;
        wait_ready(n);
        check("clear2_edges_remaining", 64'(n), 64'd11);
        set_rs(10, 5);
        check("x10_dropped_in_clear", port(0), 64'd0);
        check("x5_cleared", port(1), 64'd0);

        write_reg(10, 64'hAAAA);
        write_reg(11, 64'hBBBB);
        set_rs(10, 11);
        check("x10_port0", port(0), 64'hAAAA);
        check("x11_port1", port(1), 64'hBBBB);
        set_rs(10, 10);
        check("same_reg_port0", port(0), 64'hAAAA);
        check("same_reg_port1", port(1), 64'hAAAA);

        // Clear request with simultaneous write
        write_reg(5, 64'h3333);
        set_rs(5, 7);
        check("x5_3333", port(0), 64'h3333);
        clear_request = 1'b1;
        reg_write = 1'b1;
        rd_address = 5'd7;
        write_data = 64'h7777;
        tick();
        clear_request = 1'b0;
        reg_write = 1'b0;
        #1;
        check("req_ready_falls", {63'd0, ready}, 64'd0);
        wait_ready(n);
        check("req_sweep_edges", 64'(n), 64'd31);
        set_rs(5, 7);
        check("x5_after_clear", port(0), 64'd0);
        check("x7_write_dropped", port(1), 64'd0);

        // Reset mid-sweep at counter 12
        write_reg(12, 64'h1212);
        clear_request = 1'b1;
        tick();
        clear_request = 1'b0;
        repeat (11) tick();
        reset_n = 1'b0;
        tick();
        tick();
        #1;
        check("midreset_ready", {63'd0, ready}, 64'd0);
        reset_n = 1'b1;
        wait_ready(n);
        check("midreset_edges", 64'(n), 64'd31);
        set_rs(12, 31);
        check("x12_after_midreset", port(0), 64'd0);
        check("x31_zero", port(1), 64'd0);

        // Same-cycle read of the register being written
        reg_write = 1'b1;
        rd_address = 5'd31;
        write_data = 64'hFFFFFFFFFFFFFFFF;
        set_rs(31, 0);
`ifdef PARAM_REGFILE_BYPASS_EN
        check("bypass_same_cycle", port(0), 64'hFFFFFFFFFFFFFFFF);
`else
        check("no_bypass_same_cycle", port(0), 64'd0);
`endif
        check("bypass_x0_port1", port(1), 64'd0);
        tick();
        reg_write = 1'b0;
        #1;
        check("x31_after_edge", port(0), 64'hFFFFFFFFFFFFFFFF);
        check("ready_final", {63'd0, ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
